// File: rtl/maxpool_relu_2.sv
// ---------------------------------------------------------------------------
// maxpool_relu_2
//
// Three-channel 2x2 / stride-2 max pooling followed by ReLU. Pixels arrive
// in raster order, one (row, col) position per valid_in cycle, with the
// same position on all three channels. Even rows fold each horizontal pair
// into a half-width line buffer. Odd rows combine that entry with their own
// pair to finish a window. The result is registered and flagged with a
// one-cycle valid_out.
//
// Handshake: valid_in alone qualifies conv_in_1..3. There is no ready
// signal, so every valid_in=1 cycle consumes exactly one pixel. Idle cycles
// freeze all state. valid_out is a one-cycle pulse that needs no
// acknowledge. max_value_* hold their last value between pulses.
//
// Optional build macro:
//   MAXPOOL2_SAT_EN - when defined, positive results above 2^OUT_BIT-1
//                     clamp to 2^OUT_BIT-1. Otherwise the low OUT_BIT bits
//                     are kept.
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     asynchronous active-low reset
//   valid_in                  conv_in_1..3 carry a pixel this cycle
//   conv_in_1..3  [IN_BIT]    signed samples, one per channel
//   max_value_1..3 [OUT_BIT]  pooled, ReLU'd outputs, one per channel
//   valid_out                 max_value_* updated this cycle
//   frame_done                coincident with the last valid_out of a frame
// ---------------------------------------------------------------------------
module maxpool_relu_2 #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int IN_BIT  = 14,
    parameter int OUT_BIT = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [IN_BIT-1:0] conv_in_1,
    input  logic signed [IN_BIT-1:0] conv_in_2,
    input  logic signed [IN_BIT-1:0] conv_in_3,
    output logic [OUT_BIT-1:0]       max_value_1,
    output logic [OUT_BIT-1:0]       max_value_2,
    output logic [OUT_BIT-1:0]       max_value_3,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int NCH    = 3;
    localparam int HALF_W = WIDTH / 2;
    localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int HIW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    // Raster position of the next pixel to be consumed.
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [HIW-1:0] half_idx;

    logic signed [IN_BIT-1:0] sample   [NCH];
    logic signed [IN_BIT-1:0] latch_q  [NCH];
    logic signed [IN_BIT-1:0] line_buf [NCH][HALF_W];
    logic signed [IN_BIT-1:0] win      [NCH];
    logic [OUT_BIT-1:0]       max_q    [NCH];

    logic last_col;
    logic last_row;

    // Signed maximum. On a tie either operand is the same value.
    function automatic logic signed [IN_BIT-1:0] smax(
        input logic signed [IN_BIT-1:0] a,
        input logic signed [IN_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // ReLU followed by narrowing to OUT_BIT.
    function automatic logic [OUT_BIT-1:0] relu_out(
        input logic signed [IN_BIT-1:0] v
    );
        logic [OUT_BIT-1:0] r;
`ifdef MAXPOOL2_SAT_EN
        if (v[IN_BIT-1]) begin
            r = '0;
        end else if ({{OUT_BIT{1'b0}}, v} > {{IN_BIT{1'b0}}, {OUT_BIT{1'b1}}}) begin
            r = '1;
        end else begin
            r = OUT_BIT'($unsigned(v));
        end
`else
        if (v[IN_BIT-1]) begin
            r = '0;
        end else begin
            r = OUT_BIT'($unsigned(v));
        end
`endif
        return r;
    endfunction

    assign sample[0] = conv_in_1;
    assign sample[1] = conv_in_2;
    assign sample[2] = conv_in_3;

    // Line-buffer slot shared by the two columns of a pooling window.
    assign half_idx = HIW'(col >> 1);
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));

    // Full window maximum. It is only used on the odd-row, odd-col pixel.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            win[ch] = smax(smax(line_buf[ch][half_idx], latch_q[ch]), sample[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                latch_q[ch] <= '0;
                max_q[ch]   <= '0;
                for (int i = 0; i < HALF_W; i++) begin
                    line_buf[ch][i] <= '0;
                end
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (!col[0]) begin
                        latch_q[ch] <= sample[ch];
                    end else if (!row[0]) begin
                        line_buf[ch][half_idx] <= smax(latch_q[ch], sample[ch]);
                    end else begin
                        max_q[ch] <= relu_out(win[ch]);
                    end
                end

                if (row[0] && col[0]) begin
                    valid_out  <= 1'b1;
                    frame_done <= last_row && last_col;
                end

                // Advance the raster position, wrapping at the end of each row and frame.
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign max_value_1 = max_q[0];
    assign max_value_2 = max_q[1];
    assign max_value_3 = max_q[2];

endmodule

// File: tb/tb_maxpool_relu_2.sv
module tb_maxpool_relu_2;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int IB  = 14;
    localparam int OB  = 12;
    localparam int EW  = 2 + 3 * OB;   // {valid_out, frame_done, m1, m2, m3}
    localparam int MAX_OUT = (1 << OB) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic signed [IB-1:0] conv_in_1 = '0;
    logic signed [IB-1:0] conv_in_2 = '0;
    logic signed [IB-1:0] conv_in_3 = '0;
    logic [OB-1:0] max_value_1;
    logic [OB-1:0] max_value_2;
    logic [OB-1:0] max_value_3;
    logic valid_out;
    logic frame_done;

    always #5 clk = ~clk;

    maxpool_relu_2 #(
        .WIDTH  (W),
        .HEIGHT (H),
        .IN_BIT (IB),
        .OUT_BIT(OB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .conv_in_1  (conv_in_1),
        .conv_in_2  (conv_in_2),
        .conv_in_3  (conv_in_3),
        .max_value_1(max_value_1),
        .max_value_2(max_value_2),
        .max_value_3(max_value_3),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [3*OB-1:0] last_vals = '0;
    int frame [3][H][W];

    typedef struct packed {
        logic [11:0][IB-1:0] px;   // [ch*4 + k], k = 0:(0,0) 1:(0,1) 2:(1,0) 3:(1,1)
        logic [2:0][OB-1:0]  ex;
    } win_vec_t;

    localparam int NVEC = 5;
    win_vec_t tv [NVEC];

    // ---------------- reference model ----------------
    function automatic int relu_ref(input int v);
        if (v < 0) return 0;
`ifdef MAXPOOL2_SAT_EN
        if (v > MAX_OUT) return MAX_OUT;
        return v;
`else
        return v % (MAX_OUT + 1);
`endif
    endfunction

    function automatic logic [EW-1:0] pack_exp(input bit v, input bit d, input int a, input int b, input int c);
        return {v, d, OB'(a), OB'(b), OB'(c)};
    endfunction

    function automatic logic [EW-1:0] get_act();
        return {valid_out, frame_done, max_value_1, max_value_2, max_value_3};
    endfunction

    function automatic win_vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                    input int b0, input int b1, input int b2, input int b3,
                                    input int c0, input int c1, input int c2, input int c3,
                                    input int e1, input int e2, input int e3);
        win_vec_t v;
        v.px[0]  = IB'(a0); v.px[1]  = IB'(a1); v.px[2]  = IB'(a2); v.px[3]  = IB'(a3);
        v.px[4]  = IB'(b0); v.px[5]  = IB'(b1); v.px[6]  = IB'(b2); v.px[7]  = IB'(b3);
        v.px[8]  = IB'(c0); v.px[9]  = IB'(c1); v.px[10] = IB'(c2); v.px[11] = IB'(c3);
        v.ex[0]  = OB'(e1); v.ex[1]  = OB'(e2); v.ex[2]  = OB'(e3);
        return v;
    endfunction

    // Pooled map of the current frame, in raster order, from plain max over each 2x2 block.
    task automatic model_fill();
        for (int pr = 0; pr < H / 2; pr++) begin
            for (int pc = 0; pc < W / 2; pc++) begin
                int m [3];
                for (int ch = 0; ch < 3; ch++) begin
                    m[ch] = frame[ch][2*pr][2*pc];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (frame[ch][2*pr+dr][2*pc+dc] > m[ch]) m[ch] = frame[ch][2*pr+dr][2*pc+dc];
                end
                exp_q.push_back(pack_exp(1'b1, (pr == H/2-1) && (pc == W/2-1),
                                         relu_ref(m[0]), relu_ref(m[1]), relu_ref(m[2])));
            end
        end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    frame[ch][r][c] = int'($signed(IB'($urandom_range(0, (1 << IB) - 1))));
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got v=%0b d=%0b m=%0d,%0d,%0d expected v=%0b d=%0b m=%0d,%0d,%0d",
                     name, $time, act[EW-1], act[EW-2], act[3*OB-1:2*OB], act[2*OB-1:OB], act[OB-1:0],
                     exp[EW-1], exp[EW-2], exp[3*OB-1:2*OB], exp[2*OB-1:OB], exp[OB-1:0]);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_cycle();
        valid_in  = 1'b0;
        conv_in_1 = IB'($urandom);
        conv_in_2 = IB'($urandom);
        conv_in_3 = IB'($urandom);
        @(posedge clk); #1;
        check("idle_hold", get_act(), {2'b00, last_vals});
    endtask

    // Drive the first npix pixels of frame in raster order with 0..max_gap idle cycles before each.
    task automatic drive_pixels(input int npix, input int max_gap);
        for (int k = 0; k < npix; k++) begin
            int r;
            int c;
            int gap;
            logic [EW-1:0] e;
            r = k / W;
            c = k % W;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) idle_cycle();
            valid_in  = 1'b1;
            conv_in_1 = IB'(frame[0][r][c]);
            conv_in_2 = IB'(frame[1][r][c]);
            conv_in_3 = IB'(frame[2][r][c]);
            @(posedge clk); #1;
            valid_in = 1'b0;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exp_q_underflow @%0t: got empty queue expected an entry", $time);
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    check("window", get_act(), e);
                end
                last_vals = e[3*OB-1:0];
            end else begin
                check("no_output", get_act(), {2'b00, last_vals});
            end
        end
    endtask

    task automatic check_drained();
        check("queue_drained", EW'(exp_q.size()), '0);
    endtask

    // ---------------- test ----------------
    initial begin
        tv[0] = mk(100, -200, 300, 7,  -1, -1, -1, -1,  0, 0, 0, 0,  300, 0, 0);
        tv[1] = mk(-5, -5, -5, -5,  -5, -5, -5, -5,  -5, -5, -5, -5,  0, 0, 0);
`ifdef MAXPOOL2_SAT_EN
        tv[2] = mk(5000, 1, 2, 3,  -8192, 8191, 0, 0,  4095, 4096, -1, 0,  4095, 4095, 4095);
`else
        tv[2] = mk(5000, 1, 2, 3,  -8192, 8191, 0, 0,  4095, 4096, -1, 0,  904, 4095, 0);
`endif
        tv[3] = mk(7, 7, 7, 7,  -3, 9, 9, -3,  12, 12, -12, 12,  7, 9, 12);
        tv[4] = mk(1, 2, 3, 4,  40, 3, 2, 1,  -9, -8, 50, -7,  4, 40, 50);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", get_act(), '0);
        rst_n = 1'b1;

        // Ramp frame: value = row*8+col, continuous valid_in.
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    frame[ch][r][c] = r * W + c;
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++) begin
                int v;
                v = (2 * pr + 1) * W + 2 * pc + 1;
                exp_q.push_back(pack_exp(1'b1, (pr == H/2-1) && (pc == W/2-1), v, v, v));
            end
        drive_pixels(W * H, 0);
        check_drained();

        // Table of uniform-window frames, back to back with no dead cycle.
        for (int i = 0; i < NVEC; i++) begin
            for (int ch = 0; ch < 3; ch++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        frame[ch][r][c] = int'($signed(tv[i].px[ch*4 + (r % 2) * 2 + (c % 2)]));
            for (int k = 0; k < (W / 2) * (H / 2); k++)
                exp_q.push_back(pack_exp(1'b1, k == (W / 2) * (H / 2) - 1,
                                         int'(tv[i].ex[0]), int'(tv[i].ex[1]), int'(tv[i].ex[2])));
            drive_pixels(W * H, 0);
            check_drained();
        end

        // Random frame gap-free, then the same frame with 0-3 idle cycles between pixels.
        fill_random();
        model_fill();
        drive_pixels(W * H, 0);
        check_drained();
        model_fill();
        drive_pixels(W * H, 3);
        check_drained();

        // More random frames with gaps.
        for (int f = 0; f < 3; f++) begin
            fill_random();
            model_fill();
            drive_pixels(W * H, 3);
            check_drained();
        end

        // Reset after 37 pixels, then a full frame.
        fill_random();
        model_fill();
        drive_pixels(37, 0);
        valid_in  = 1'b1;
        conv_in_1 = IB'(1000);
        conv_in_2 = IB'(2000);
        conv_in_3 = IB'(3000);
        rst_n = 1'b0;
        #1;
        check("reset_async", get_act(), '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", get_act(), '0);
        end
        valid_in = 1'b0;
        exp_q.delete();
        last_vals = '0;
        rst_n = 1'b1;
        idle_cycle();
        fill_random();
        model_fill();
        drive_pixels(W * H, 0);
        check_drained();
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
